mem_wb_stage: RTL and testbench

- Memory/writeback stage of the pipeline. Sits between EX and the register file.
- Accepts one EX result per handshake and passes ALU results straight through.
- Runs loads and stores as single AHB-Lite master transfers.
- Drives rd_sel, reg_write, wb_en and wb_data straight into the register file's write port.

---
 rtl/mem_wb_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: ALU results pass straight to the register file write port,
// loads/stores run as single AHB-Lite transfers with alignment, error and timeout handling.
//   state  | meaning
//   IDLE   | ready for EX; ALU ops write back next cycle, misaligned ops flag mem_err
//   ADDR   | AHB address phase (NONSEQ), held while HREADY is low
//   DATA   | AHB data phase, counting HREADY-low cycles toward WAIT_LIMIT
module mem_wb_stage #(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_store_data,
  input  logic [31:0] ex_alu_result,
  input  logic [4:0]  ex_rd_sel,
  input  logic        ex_reg_write,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        wb_en,
  output logic        reg_write,
  output logic [4:0]  rd_sel,
  output logic [31:0] wb_data,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  localparam logic [7:0] WAIT_LIMIT8 = 8'(WAIT_LIMIT);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        is_store_q, is_store_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        wb_en_q, wb_en_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  rd_sel_q, rd_sel_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        mem_err_q, mem_err_d;

  logic        misaligned;
  logic [31:0] store_lanes;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;
  logic [7:0]  wait_inc;

  // Unsupported funct3 encodings are rejected the same way as misaligned accesses.
  always_comb begin
    misaligned = 1'b1;
    case (ex_funct3)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = ex_addr[0];
      3'b010:         misaligned = |ex_addr[1:0];
      default:        misaligned = 1'b1;
    endcase
  end

  always_comb begin
    store_lanes = ex_store_data;
    case (ex_funct3[1:0])
      2'b00:   store_lanes = {4{ex_store_data[7:0]}};
      2'b01:   store_lanes = {2{ex_store_data[15:0]}};
      default: store_lanes = ex_store_data;
    endcase
  end

  always_comb begin
    ld_byte = HRDATA[7:0];
    case (addr_q[1:0])
      2'b00: ld_byte = HRDATA[7:0];
      2'b01: ld_byte = HRDATA[15:8];
      2'b10: ld_byte = HRDATA[23:16];
      2'b11: ld_byte = HRDATA[31:24];
    endcase
    ld_half = addr_q[1] ? HRDATA[31:16] : HRDATA[15:0];
    ld_value = HRDATA;
    case (funct3_q)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_value = {24'b0, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_value = {16'b0, ld_half};
      default: ld_value = HRDATA;
    endcase
  end

  assign wait_inc = wait_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    funct3_d    = funct3_q;
    is_store_d  = is_store_q;
    hwdata_d    = hwdata_q;
    rd_d        = rd_q;
    rw_d        = rw_q;
    wait_cnt_d  = wait_cnt_q;
    wb_en_d     = 1'b0;
    reg_write_d = reg_write_q;
    rd_sel_d    = rd_sel_q;
    wb_data_d   = wb_data_q;
    mem_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          if (ex_is_load || ex_is_store) begin
            if (misaligned) begin
              mem_err_d   = 1'b1;
              reg_write_d = 1'b0;
            end else begin
              addr_d     = ex_addr;
              funct3_d   = ex_funct3;
              is_store_d = ex_is_store;
              hwdata_d   = store_lanes;
              rd_d       = ex_rd_sel;
              rw_d       = ex_reg_write;
              state_d    = S_ADDR;
            end
          end else begin
            wb_en_d     = 1'b1;
            reg_write_d = ex_reg_write;
            rd_sel_d    = ex_rd_sel;
            wb_data_d   = ex_alu_result;
          end
        end
      end
      S_ADDR: begin
        if (HREADY) begin
          state_d    = S_DATA;
          wait_cnt_d = 8'd0;
        end
      end
      S_DATA: begin
        if (HREADY) begin
          state_d = S_IDLE;
          if (HRESP) begin
            mem_err_d   = 1'b1;
            reg_write_d = 1'b0;
          end else begin
            wb_en_d     = 1'b1;
            rd_sel_d    = rd_q;
            reg_write_d = is_store_q ? 1'b0 : rw_q;
            if (!is_store_q) wb_data_d = ld_value;
          end
        end else if (wait_inc == WAIT_LIMIT8) begin
          state_d     = S_IDLE;
          mem_err_d   = 1'b1;
          reg_write_d = 1'b0;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= 32'b0;
      funct3_q    <= 3'b0;
      is_store_q  <= 1'b0;
      hwdata_q    <= 32'b0;
      rd_q        <= 5'b0;
      rw_q        <= 1'b0;
      wait_cnt_q  <= 8'b0;
      wb_en_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_sel_q    <= 5'b0;
      wb_data_q   <= 32'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      funct3_q    <= funct3_d;
      is_store_q  <= is_store_d;
      hwdata_q    <= hwdata_d;
      rd_q        <= rd_d;
      rw_q        <= rw_d;
      wait_cnt_q  <= wait_cnt_d;
      wb_en_q     <= wb_en_d;
      reg_write_q <= reg_write_d;
      rd_sel_q    <= rd_sel_d;
      wb_data_q   <= wb_data_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign ex_ready  = (state_q == S_IDLE);
  assign HTRANS    = (state_q == S_ADDR) ? 2'b10 : 2'b00;
  assign HADDR     = addr_q;
  assign HWRITE    = is_store_q;
  assign HSIZE     = {1'b0, funct3_q[1:0]};
  assign HWDATA    = hwdata_q;
  assign wb_en     = wb_en_q;
  assign reg_write = reg_write_q;
  assign rd_sel    = rd_sel_q;
  assign wb_data   = wb_data_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: stimulus pushes expected writebacks and bus
// address phases; two negedge monitors pop and compare as the DUT presents them.
module tb_mem_wb_stage;
  localparam int WL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0, ex_ready;
  logic        ex_is_load = 1'b0, ex_is_store = 1'b0;
  logic [2:0]  ex_funct3 = 3'b0;
  logic [31:0] ex_addr = 32'b0, ex_store_data = 32'b0, ex_alu_result = 32'b0;
  logic [4:0]  ex_rd_sel = 5'b0;
  logic        ex_reg_write = 1'b0;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HRDATA = 32'b0;
  logic        HREADY = 1'b1, HRESP = 1'b0;
  logic        wb_en, reg_write, mem_err;
  logic [4:0]  rd_sel;
  logic [31:0] wb_data;

  mem_wb_stage #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_funct3(ex_funct3),
    .ex_addr(ex_addr), .ex_store_data(ex_store_data), .ex_alu_result(ex_alu_result),
    .ex_rd_sel(ex_rd_sel), .ex_reg_write(ex_reg_write),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .wb_en(wb_en), .reg_write(reg_write), .rd_sel(rd_sel), .wb_data(wb_data),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_err;
    int          cyc;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } bus_exp_t;

  wb_exp_t  wb_q[$];
  bus_exp_t bus_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Writeback/error monitor
  always @(negedge clk) begin
    wb_exp_t e;
    if (!reset && (wb_en || mem_err)) begin
      if (wb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: wb_en=%0b mem_err=%0b with nothing expected (cycle %0d)",
                 wb_en, mem_err, cyc);
      end else begin
        e = wb_q.pop_front();
        chk("out_cycle", cyc, e.cyc);
        chk("mem_err", {31'b0, mem_err}, {31'b0, e.is_err});
        chk("wb_en", {31'b0, wb_en}, {31'b0, !e.is_err});
        chk("reg_write", {31'b0, reg_write}, e.is_err ? 32'd0 : {31'b0, e.rw});
        if (!e.is_err) chk("rd_sel", {27'b0, rd_sel}, {27'b0, e.rd});
        if (e.chk_data) chk("wb_data", wb_data, e.data);
      end
    end
  end

  // Bus monitor: address phase fields, then HTRANS/HWDATA in the first data cycle
  logic     pend = 1'b0;
  bus_exp_t cur;
  always @(negedge clk) begin
    bus_exp_t b;
    if (reset) begin
      pend <= 1'b0;
    end else begin
      if (pend) begin
        chk("htrans_data", {30'b0, HTRANS}, 32'd0);
        if (cur.wr) chk("hwdata", HWDATA, cur.wdata);
        pend <= 1'b0;
      end
      if (HTRANS == 2'b10 && HREADY) begin
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_transfer: HTRANS=%0b HADDR=0x%0h (cycle %0d)", HTRANS, HADDR, cyc);
        end else begin
          b = bus_q.pop_front();
          chk("haddr", HADDR, b.addr);
          chk("hwrite", {31'b0, HWRITE}, {31'b0, b.wr});
          chk("hsize", {29'b0, HSIZE}, {29'b0, b.size});
          cur  <= b;
          pend <= 1'b1;
        end
      end
    end
  end

  task automatic alu_op(input logic [31:0] res, input logic [4:0] rd, input logic rw);
    wb_exp_t e;
    chk("ready_alu", {31'b0, ex_ready}, 32'd1);
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_is_store = 1'b0;
    ex_alu_result = res; ex_rd_sel = rd; ex_reg_write = rw; ex_addr = 32'hFFFF_FFFF;
    e = '{1'b0, cyc + 1, rw, rd, res, 1'b1};
    wb_q.push_back(e);
    @(posedge clk); #1;
  endtask

  // kind: 0 ok, 1 misaligned/invalid, 2 bus error, 3 timeout
  task automatic mem_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                        input logic rw, input int a, input int w, input logic [31:0] rdata,
                        input int kind, input logic [2:0] esize, input logic [31:0] ewdata,
                        input logic [31:0] edata);
    wb_exp_t  e;
    bus_exp_t b;
    int       nlow;
    chk("ready_idle", {31'b0, ex_ready}, 32'd1);
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
    ex_addr = addr; ex_store_data = sd; ex_rd_sel = rd; ex_reg_write = rw;
    ex_alu_result = 32'h5A5A_5A5A;
    if (kind == 1) begin
      e = '{1'b1, cyc + 1, 1'b0, rd, 32'b0, 1'b0};
      wb_q.push_back(e);
      @(posedge clk); #1;
      ex_valid = 1'b0;
      chk("no_trans", {30'b0, HTRANS}, 32'd0);
      chk("ready_after_err", {31'b0, ex_ready}, 32'd1);
      return;
    end
    nlow = (kind == 3) ? WL : w;
    b = '{addr, st, esize, ewdata};
    bus_q.push_back(b);
    e = '{kind != 0, cyc + 3 + a + ((kind == 3) ? WL - 1 : w), st ? 1'b0 : rw, rd, edata,
          ld && (kind == 0)};
    wb_q.push_back(e);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    for (int i = 0; i < a; i++) begin
      HREADY = 1'b0;
      chk("ready_busy", {31'b0, ex_ready}, 32'd0);
      chk("htrans_addr", {30'b0, HTRANS}, 32'd2);
      @(posedge clk); #1;
    end
    HREADY = 1'b1;
    chk("ready_busy", {31'b0, ex_ready}, 32'd0);
    chk("htrans_addr", {30'b0, HTRANS}, 32'd2);
    @(posedge clk); #1;
    for (int i = 0; i < nlow; i++) begin
      HREADY = 1'b0;
      chk("ready_busy", {31'b0, ex_ready}, 32'd0);
      @(posedge clk); #1;
    end
    if (kind != 3) begin
      HREADY = 1'b1; HRESP = (kind == 2); HRDATA = rdata;
      chk("ready_busy", {31'b0, ex_ready}, 32'd0);
      @(posedge clk); #1;
    end
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'b0;
    chk("ready_done", {31'b0, ex_ready}, 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_htrans"}, {30'b0, HTRANS}, 32'd0);
    chk({tag, "_haddr"}, HADDR, 32'd0);
    chk({tag, "_hwrite"}, {31'b0, HWRITE}, 32'd0);
    chk({tag, "_hsize"}, {29'b0, HSIZE}, 32'd0);
    chk({tag, "_hwdata"}, HWDATA, 32'd0);
    chk({tag, "_wb_en"}, {31'b0, wb_en}, 32'd0);
    chk({tag, "_reg_write"}, {31'b0, reg_write}, 32'd0);
    chk({tag, "_rd_sel"}, {27'b0, rd_sel}, 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_mem_err"}, {31'b0, mem_err}, 32'd0);
    chk({tag, "_ex_ready"}, {31'b0, ex_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    alu_op(32'h0000_1234, 5'd5, 1'b1);
    alu_op(32'hDEAD_BEEF, 5'd6, 1'b1);
    alu_op(32'h0000_0042, 5'd0, 1'b0);
    ex_valid = 1'b0;
    @(posedge clk); #1;

    //     ld    st    f3      addr          sd            rd    rw  a  w  rdata         kind size    wdata         expected
    mem_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        5'd7,  1, 0, 0, 32'h80FF_0000, 0, 3'b000, 32'h0,        32'hFFFF_FF80);
    mem_op(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,        5'd8,  1, 0, 3, 32'h8001_0000, 0, 3'b001, 32'h0,        32'h0000_8001);
    mem_op(1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 5'd0, 1, 0, 1, 32'h0,         0, 3'b000, 32'hABAB_ABAB, 32'h0);
    mem_op(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0,        5'd9,  1, 0, 0, 32'h0,         1, 3'b010, 32'h0,        32'h0);
    mem_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        5'd9,  1, 0, 1, 32'h1357_9BDF, 2, 3'b010, 32'h0,        32'h0);
    mem_op(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0,        5'd9,  1, 0, 0, 32'h0,         3, 3'b010, 32'h0,        32'h0);
    mem_op(1'b1, 1'b0, 3'b010, 32'h0000_0108, 32'h0,        5'd10, 1, 1, 3, 32'h1122_3344, 0, 3'b010, 32'h0,        32'h1122_3344);
    mem_op(1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0,        5'd11, 1, 0, 0, 32'hF00D_0000, 0, 3'b001, 32'h0,        32'hFFFF_F00D);
    mem_op(1'b1, 1'b0, 3'b100, 32'h0000_0001, 32'h0,        5'd12, 1, 0, 0, 32'h0000_9A00, 0, 3'b000, 32'h0,        32'h0000_009A);
    mem_op(1'b1, 1'b0, 3'b000, 32'h0000_0000, 32'h0,        5'd13, 1, 0, 2, 32'hFFFF_FF7F, 0, 3'b000, 32'h0,        32'h0000_007F);
    mem_op(1'b0, 1'b1, 3'b001, 32'h0000_0002, 32'h1234_5678, 5'd0, 1, 0, 0, 32'h0,         0, 3'b001, 32'h5678_5678, 32'h0);
    mem_op(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_BABE, 5'd0, 1, 2, 1, 32'h0,         0, 3'b010, 32'hCAFE_BABE, 32'h0);
    mem_op(1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0,        5'd14, 1, 0, 0, 32'h0,         1, 3'b011, 32'h0,        32'h0);
    mem_op(1'b1, 1'b0, 3'b001, 32'h0000_0001, 32'h0,        5'd14, 1, 0, 0, 32'h0,         1, 3'b001, 32'h0,        32'h0);
    alu_op(32'h7777_0000, 5'd3, 1'b1);
    ex_valid = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a stalled address phase
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0; ex_funct3 = 3'b010;
    ex_addr = 32'h0000_0300; ex_rd_sel = 5'd14; ex_reg_write = 1'b1;
    HREADY = 1'b0;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("rst_htrans_addr", {30'b0, HTRANS}, 32'd2);
    chk("rst_haddr", HADDR, 32'h0000_0300);
    @(posedge clk); #1;
    chk("hold_htrans", {30'b0, HTRANS}, 32'd2);
    chk("hold_haddr", HADDR, 32'h0000_0300);
    chk("hold_hsize", {29'b0, HSIZE}, 32'd2);
    chk("hold_ready", {31'b0, ex_ready}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    HREADY = 1'b1;
    chk_all_zero("midrst");
    @(posedge clk); #1;

    alu_op(32'h0BAD_F00D, 5'd31, 1'b1);
    ex_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("wb_queue_empty", wb_q.size(), 32'd0);
    chk("bus_queue_empty", bus_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
